// File: rtl/tiny_rv_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tiny_rv_fetch_if : instruction-memory request/response port          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tiny_rv_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rvalid, input rdata);
  modport slave  (input req, input addr, output ack, output rvalid, output rdata);
endinterface
`default_nettype wire

// File: rtl/tiny_rv_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tiny_rv_fetch : tiny_rv32 fetch stage, one outstanding imem request  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tiny_rv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        i_clk,
  input  wire logic        i_reset_n,
  input  wire logic        i_pipe_stall,
  input  wire logic        i_pipe_flush,
  input  wire logic [31:0] i_redirect_pc,
  tiny_rv_fetch_if.master  imem,
  output logic [31:0]      fetch_pc,
  output logic [31:0]      fetch_inst,
  output logic             fetch_valid
);

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic [31:0] r_buf_pc, w_buf_pc_nxt;
  logic [31:0] r_buf_inst, w_buf_inst_nxt;
  logic        r_discard, w_discard_nxt;
  logic [31:0] w_fetch_pc_nxt, w_fetch_inst_nxt;
  logic        w_fetch_valid_nxt;
  logic        w_present;
  logic [31:0] w_pres_pc, w_pres_inst;
  logic [31:0] w_redirect_pc;
  logic        w_unused_lsb;

  assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_lsb  = ^i_redirect_pc[1:0];

  assign imem.req  = i_reset_n && (r_state == S_REQ);
  assign imem.addr = r_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_pc_nxt   = r_req_pc;
    w_discard_nxt  = r_discard;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_present      = 1'b0;
    w_pres_pc      = r_buf_pc;
    w_pres_inst    = r_buf_inst;

    case (r_state)
      S_REQ: begin
        if (imem.ack) begin
          w_req_pc_nxt  = r_pc;
          w_state_nxt   = S_WAIT;
          w_discard_nxt = i_pipe_flush;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          w_state_nxt   = S_REQ;
          w_discard_nxt = 1'b0;
          if (!r_discard && !i_pipe_flush) begin
            w_pc_nxt = r_req_pc + 32'd4;
            if (i_pipe_stall) begin
              w_buf_pc_nxt   = r_req_pc;
              w_buf_inst_nxt = imem.rdata;
              w_state_nxt    = S_HOLD;
            end else begin
              w_present   = 1'b1;
              w_pres_pc   = r_req_pc;
              w_pres_inst = imem.rdata;
            end
          end
        end else if (i_pipe_flush) begin
          // Response still in flight: remember to drop it when it lands
          w_discard_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_pipe_flush) begin
          w_state_nxt = S_REQ;
        end else if (!i_pipe_stall) begin
          w_present   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase

    if (i_pipe_flush) begin
      w_pc_nxt       = w_redirect_pc;
      w_buf_pc_nxt   = 32'd0;
      w_buf_inst_nxt = 32'd0;
    end

    if (i_pipe_flush) begin
      w_fetch_pc_nxt    = 32'd0;
      w_fetch_inst_nxt  = 32'd0;
      w_fetch_valid_nxt = 1'b0;
    end else if (w_present) begin
      w_fetch_pc_nxt    = w_pres_pc;
      w_fetch_inst_nxt  = w_pres_inst;
      w_fetch_valid_nxt = 1'b1;
    end else if (i_pipe_stall) begin
      w_fetch_pc_nxt    = fetch_pc;
      w_fetch_inst_nxt  = fetch_inst;
      w_fetch_valid_nxt = fetch_valid;
    end else begin
      w_fetch_pc_nxt    = 32'd0;
      w_fetch_inst_nxt  = 32'd0;
      w_fetch_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_REQ;
      r_pc        <= c_reset_pc;
      r_req_pc    <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= 32'd0;
      r_discard   <= 1'b0;
      fetch_pc    <= 32'd0;
      fetch_inst  <= 32'd0;
      fetch_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_buf_inst  <= w_buf_inst_nxt;
      r_discard   <= w_discard_nxt;
      fetch_pc    <= w_fetch_pc_nxt;
      fetch_inst  <= w_fetch_inst_nxt;
      fetch_valid <= w_fetch_valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tiny_rv_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tiny_rv_fetch : directed + random bench for tiny_rv_fetch         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tiny_rv_fetch;

  localparam logic [31:0] c_reset_pc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_valid;

  int n_checks = 0;
  int n_errors = 0;

  tiny_rv_fetch_if imem ();

  tiny_rv_fetch #(.RESET_PC(c_reset_pc)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_pipe_stall  (stall),
    .i_pipe_flush  (flush),
    .i_redirect_pc (redirect_pc),
    .imem          (imem),
    .fetch_pc      (fetch_pc),
    .fetch_inst    (fetch_inst),
    .fetch_valid   (fetch_valid)
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding-request flag, a "response is stale" flag
  // and a queue of instructions waiting for the stall to lift.
  bit          m_known;
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_req_pc;
  logic [63:0] m_hold_q[$];
  logic [31:0] m_out_pc, m_out_inst;
  logic        m_out_valid;

  bit mem_busy;
  int mem_delay;

  function automatic bit m_requesting();
    return !m_busy && (m_hold_q.size() == 0);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic st, input logic fl,
                            input logic [31:0] rd, input logic ak, input logic rv,
                            input logic [31:0] data);
    bit          hs, resp, present;
    logic [63:0] pres;
    if (!rn) begin
      m_known = 1'b1;
      m_pc = c_reset_pc;
      m_busy = 1'b0;
      m_stale = 1'b0;
      m_hold_q.delete();
      m_out_pc = 32'd0; m_out_inst = 32'd0; m_out_valid = 1'b0;
      return;
    end
    hs = m_requesting() && ak;
    resp = m_busy && rv;
    present = 1'b0;
    pres = 64'd0;
    if (fl) begin
      m_out_pc = 32'd0; m_out_inst = 32'd0; m_out_valid = 1'b0;
      m_hold_q.delete();
      m_pc = rd & 32'hFFFF_FFFC;
      if (hs) begin
        m_busy = 1'b1; m_stale = 1'b1;
      end else if (m_busy) begin
        if (resp) begin m_busy = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
      return;
    end
    if (m_hold_q.size() != 0 && !st) begin
      pres = m_hold_q.pop_front();
      present = 1'b1;
    end else if (resp) begin
      m_busy = 1'b0;
      if (m_stale) m_stale = 1'b0;
      else begin
        m_pc = m_req_pc + 32'd4;
        if (st) m_hold_q.push_back({m_req_pc, data});
        else begin pres = {m_req_pc, data}; present = 1'b1; end
      end
    end else if (hs) begin
      m_busy = 1'b1;
      m_req_pc = m_pc;
    end
    if (present) begin
      m_out_pc = pres[63:32]; m_out_inst = pres[31:0]; m_out_valid = 1'b1;
    end else if (!st) begin
      m_out_pc = 32'd0; m_out_inst = 32'd0; m_out_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic rn, input logic st, input logic fl,
                       input logic [31:0] rd, input logic ak, input logic rv,
                       input logic [31:0] data);
    bit exp_req;
    @(negedge clk);
    reset_n = rn; stall = st; flush = fl; redirect_pc = rd;
    imem.ack = ak; imem.rvalid = rv; imem.rdata = data;
    #1;
    exp_req = rn && m_requesting();
    check32("req", {31'd0, imem.req}, {31'd0, exp_req});
    if (exp_req && m_known) check32("addr", imem.addr, m_pc);
    if (m_known) begin
      check32("fetch_pc", fetch_pc, m_out_pc);
      check32("fetch_inst", fetch_inst, m_out_inst);
      check32("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_out_valid});
    end
    model_step(rn, st, fl, rd, ak, rv, data);
  endtask

  initial begin
    logic rn, st, fl, ak, rv;
    logic [31:0] rd, data;

    m_known = 1'b0; m_busy = 1'b0; m_stale = 1'b0;
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    imem.ack = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'd0;

    // Reset, immediate ack, rvalid one cycle later
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check32("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check32("rst_pc", fetch_pc, 32'd0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    check32("first_addr", imem.addr, 32'h100);
    cycle(1, 0, 0, 0, 0, 1, 32'h0050_0093);
    cycle(1, 0, 0, 0, 1, 0, 0);
    check32("s1_pc", fetch_pc, 32'h100);
    check32("s1_inst", fetch_inst, 32'h0050_0093);
    check32("s1_addr2", imem.addr, 32'h104);
    cycle(1, 0, 0, 0, 0, 1, 32'h00a0_0113);
    cycle(1, 0, 0, 0, 1, 0, 0);
    check32("s1_addr3", imem.addr, 32'h108);

    // Ack held low for three cycles
    cycle(1, 0, 0, 0, 0, 1, 32'h0000_0013);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check32("noack_req", {31'd0, imem.req}, 32'd1);
    check32("noack_addr", imem.addr, 32'h10c);

    // Stall in WAIT, response arrives, stall held, then released
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 32'hdead_beef);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1, 1, 32'h1111_1111);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check32("hold_pc", fetch_pc, 32'h10c);
    check32("hold_inst", fetch_inst, 32'hdead_beef);
    check32("hold_next", imem.addr, 32'h110);

    // Flush in WAIT, response next cycle is dropped
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 1, 32'h2002, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 32'h2222_2222);
    check32("flush_valid", {31'd0, fetch_valid}, 32'd0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check32("flush_addr", imem.addr, 32'h2000);

    // Flush, rvalid and stall together
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 1, 1, 32'h3001, 0, 1, 32'h3333_3333);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check32("fsr_valid", {31'd0, fetch_valid}, 32'd0);
    check32("fsr_addr", imem.addr, 32'h3000);

    // Wraparound at the top of the address space
    cycle(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 32'h4444_4444);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check32("wrap_addr", imem.addr, 32'h0);
    check32("wrap_pc", fetch_pc, 32'hFFFF_FFFC);

    // Reset during WAIT followed by a late response
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 32'h5555_5555);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check32("late_valid", {31'd0, fetch_valid}, 32'd0);
    check32("late_addr", imem.addr, c_reset_pc);

    // Randomised traffic
    mem_busy = 1'b0;
    mem_delay = 0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 79) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 11) == 0);
      rd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      ak = ($urandom_range(0, 2) != 0);
      data = $urandom;
      rv = 1'b0;
      if (mem_busy) begin
        if (mem_delay == 0) begin rv = 1'b1; mem_busy = 1'b0; end
        else mem_delay--;
      end else begin
        rv = ($urandom_range(0, 7) == 0);
      end
      if (!rn) mem_busy = 1'b0;
      else if (m_requesting() && ak) begin
        mem_busy = 1'b1;
        mem_delay = $urandom_range(0, 2);
      end
      cycle(rn, st, fl, rd, ak, rv, data);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
